// File: rtl/spwm_phase_scheduler.sv
// SPWM phase scheduler: phase accumulator plus three-phase sample fetch
// from one shared ROM. Optional ack watchdog: SPWM_ACK_TIMEOUT_EN.
module spwm_phase_scheduler #(
   parameter int ADDR_BITS   = 8,
   parameter int SAMPLE_BITS = 12,
   parameter int ACC_BITS    = 32,
   parameter int UPDATE_DIV  = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [ACC_BITS-1:0]    tuning_word,
   input  logic                   tw_load,
   input  logic                   flags_clr,
   output logic                   rom_req,
   output logic [ADDR_BITS-1:0]   rom_addr,
   input  logic                   rom_ack,
   input  logic [SAMPLE_BITS-1:0] rom_data,
   output logic [SAMPLE_BITS-1:0] sample_a,
   output logic [SAMPLE_BITS-1:0] sample_b,
   output logic [SAMPLE_BITS-1:0] sample_c,
   output logic                   samples_valid,
   output logic                   busy,
   output logic                   overrun,
   output logic                   rom_error
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH_A = 2'd1,
      FETCH_B = 2'd2,
      FETCH_C = 2'd3
   } state_t;

   localparam int PS_BITS = $clog2(UPDATE_DIV);
   localparam logic [PS_BITS-1:0] PS_MAX = PS_BITS'(UPDATE_DIV - 1);

   // 120 degrees is a third of the table, rounded down
   localparam int OFS = (2 ** ADDR_BITS) / 3;
   localparam logic [ADDR_BITS-1:0] OFS_1 = ADDR_BITS'(OFS);
   localparam logic [ADDR_BITS-1:0] OFS_2 = ADDR_BITS'(2 * OFS);

   state_t state;
   state_t state_nxt;

   logic [PS_BITS-1:0]     prescaler;
   logic                   tick;
   logic                   accept_tick;
   logic [ACC_BITS-1:0]    phase_acc;
   logic [ACC_BITS-1:0]    tw_pending;
   logic [ACC_BITS-1:0]    tw_active;
   logic [ADDR_BITS-1:0]   base;
   logic [ADDR_BITS-1:0]   addr_b;
   logic [ADDR_BITS-1:0]   addr_c;
   logic [SAMPLE_BITS-1:0] shadow_a;
   logic [SAMPLE_BITS-1:0] shadow_b;
   logic                   cap_a;
   logic                   cap_b;
   logic                   commit;
   logic                   wd_expire;

   assign tick        = enable && (prescaler == PS_MAX);
   assign accept_tick = tick && (state == IDLE);
   assign busy        = (state != IDLE);

   assign base   = phase_acc[ACC_BITS-1 -: ADDR_BITS];
   assign addr_b = base + OFS_1;
   assign addr_c = base + OFS_2;

   // update-rate prescaler, frozen while disabled
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prescaler <= '0;
      end else if (enable) begin
         if (prescaler == PS_MAX)
            prescaler <= '0;
         else
            prescaler <= prescaler + 1'b1;
      end
   end

   // tuning word staging and phase accumulation on accepted ticks
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tw_pending <= '0;
         tw_active  <= '0;
         phase_acc  <= '0;
      end else begin
         if (tw_load)
            tw_pending <= tuning_word;
         if (accept_tick) begin
            tw_active <= tw_pending;
            phase_acc <= phase_acc + tw_pending;
         end
      end
   end

   // fsm state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // fsm next state and fetch request decode
   always_comb begin
      state_nxt = state;
      rom_req   = 1'b0;
      rom_addr  = '0;
      cap_a     = 1'b0;
      cap_b     = 1'b0;
      commit    = 1'b0;
      unique case (state)
         IDLE: begin
            if (tick)
               state_nxt = FETCH_A;
         end
         FETCH_A: begin
            rom_req  = 1'b1;
            rom_addr = base;
            if (rom_ack) begin
               cap_a     = 1'b1;
               state_nxt = FETCH_B;
            end else if (wd_expire) begin
               state_nxt = IDLE;
            end
         end
         FETCH_B: begin
            rom_req  = 1'b1;
            rom_addr = addr_b;
            if (rom_ack) begin
               cap_b     = 1'b1;
               state_nxt = FETCH_C;
            end else if (wd_expire) begin
               state_nxt = IDLE;
            end
         end
         FETCH_C: begin
            rom_req  = 1'b1;
            rom_addr = addr_c;
            if (rom_ack) begin
               commit    = 1'b1;
               state_nxt = IDLE;
            end else if (wd_expire) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // shadow capture and simultaneous three-phase commit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_a      <= '0;
         shadow_b      <= '0;
         sample_a      <= '0;
         sample_b      <= '0;
         sample_c      <= '0;
         samples_valid <= 1'b0;
      end else begin
         samples_valid <= commit;
         if (cap_a)
            shadow_a <= rom_data;
         if (cap_b)
            shadow_b <= rom_data;
         if (commit) begin
            sample_a <= shadow_a;
            sample_b <= shadow_b;
            sample_c <= rom_data;
         end
      end
   end

   // sticky overrun: a tick landed while a fetch was still running
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         overrun <= 1'b0;
      else if (tick && busy)
         overrun <= 1'b1;
      else if (flags_clr)
         overrun <= 1'b0;
   end

`ifdef SPWM_ACK_TIMEOUT_EN
   logic [7:0] wd_cnt;
   logic       rom_error_q;

   // watchdog counts unacknowledged cycles within one fetch state
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         wd_cnt <= '0;
      else if (state == IDLE || rom_ack || state_nxt != state)
         wd_cnt <= '0;
      else
         wd_cnt <= wd_cnt + 8'd1;
   end

   // expire on the 255th cycle spent waiting
   assign wd_expire = busy && (wd_cnt == 8'd254);

   // sticky rom_error, set on abort
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         rom_error_q <= 1'b0;
      else if (wd_expire && !rom_ack)
         rom_error_q <= 1'b1;
      else if (flags_clr)
         rom_error_q <= 1'b0;
   end

   assign rom_error = rom_error_q;
`else
   assign wd_expire = 1'b0;
   assign rom_error = 1'b0;
`endif

endmodule

// File: tb/tb_spwm_phase_scheduler.sv
// Directed bench for spwm_phase_scheduler, UPDATE_DIV=4,
// ROM model returns its own address.
module tb_spwm_phase_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [31:0] tuning_word;
   logic        tw_load;
   logic        flags_clr;
   logic        rom_req;
   logic [7:0]  rom_addr;
   logic        rom_ack;
   logic [11:0] rom_data;
   logic [11:0] sample_a;
   logic [11:0] sample_b;
   logic [11:0] sample_c;
   logic        samples_valid;
   logic        busy;
   logic        overrun;
   logic        rom_error;

   logic        stall_on;
   logic [7:0]  stall_addr;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   assign rom_data = {4'd0, rom_addr};
   assign rom_ack  = rom_req && !(stall_on && rom_addr == stall_addr);

   spwm_phase_scheduler #(
      .ADDR_BITS(8),
      .SAMPLE_BITS(12),
      .ACC_BITS(32),
      .UPDATE_DIV(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .tuning_word(tuning_word),
      .tw_load(tw_load),
      .flags_clr(flags_clr),
      .rom_req(rom_req),
      .rom_addr(rom_addr),
      .rom_ack(rom_ack),
      .rom_data(rom_data),
      .sample_a(sample_a),
      .sample_b(sample_b),
      .sample_c(sample_c),
      .samples_valid(samples_valid),
      .busy(busy),
      .overrun(overrun),
      .rom_error(rom_error)
   );

   typedef struct {
      logic        load;
      logic [31:0] tw;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [7:0]  c;
   } vec_t;

   vec_t vecs [14];

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_abc(input string name, input int a, input int b,
                            input int c);
      check({name, ".a"}, 32'(sample_a), 32'(a));
      check({name, ".b"}, 32'(sample_b), 32'(b));
      check({name, ".c"}, 32'(sample_c), 32'(c));
   endtask

   // waits for a valid pulse; strobes are cleared after one cycle
   task automatic wait_valid(input int max, output int cyc, output logic ok);
      cyc = 0;
      ok  = 1'b0;
      while (cyc < max && !ok) begin
         @(negedge clk);
         tw_load   = 1'b0;
         flags_clr = 1'b0;
         cyc++;
         if (samples_valid)
            ok = 1'b1;
      end
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      enable      = 1'b0;
      tw_load     = 1'b0;
      flags_clr   = 1'b0;
      tuning_word = '0;
      stall_on    = 1'b0;
      stall_addr  = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic start(input logic [31:0] tw);
      tuning_word = tw;
      tw_load     = 1'b1;
      enable      = 1'b1;
   endtask

   initial begin
      int   cyc;
      int   lat;
      int   n;
      int   nv;
      int   base;
      logic ok;

      vecs[0]  = '{1'b0, 32'h0,        8'd1,   8'd86, 8'd171};
      vecs[1]  = '{1'b0, 32'h0,        8'd2,   8'd87, 8'd172};
      vecs[2]  = '{1'b1, 32'h02000000, 8'd3,   8'd88, 8'd173};
      vecs[3]  = '{1'b0, 32'h0,        8'd4,   8'd89, 8'd174};
      vecs[4]  = '{1'b0, 32'h0,        8'd6,   8'd91, 8'd176};
      vecs[5]  = '{1'b1, 32'h00800000, 8'd8,   8'd93, 8'd178};
      vecs[6]  = '{1'b0, 32'h0,        8'd10,  8'd95, 8'd180};
      vecs[7]  = '{1'b0, 32'h0,        8'd10,  8'd95, 8'd180};
      vecs[8]  = '{1'b1, 32'hFE000000, 8'd11,  8'd96, 8'd181};
      vecs[9]  = '{1'b0, 32'h0,        8'd11,  8'd96, 8'd181};
      vecs[10] = '{1'b0, 32'h0,        8'd9,   8'd94, 8'd179};
      vecs[11] = '{1'b1, 32'hF8000000, 8'd7,   8'd92, 8'd177};
      vecs[12] = '{1'b0, 32'h0,        8'd5,   8'd90, 8'd175};
      vecs[13] = '{1'b0, 32'h0,        8'd253, 8'd82, 8'd167};

      // reset state
      reset = 1'b1;
      do_reset();
      check("rst.valid", 32'(samples_valid), 0);
      check("rst.busy", 32'(busy), 0);
      check("rst.req", 32'(rom_req), 0);
      check("rst.overrun", 32'(overrun), 0);
      check("rst.rom_error", 32'(rom_error), 0);
      check_abc("rst", 0, 0, 0);

      // table: commits, cadence, loads incl. load coinciding with tick
      start(32'h01000000);
      for (int i = 0; i < 14; i++) begin
         wait_valid(20, cyc, ok);
         check($sformatf("vec%0d.valid", i), 32'(ok), 1);
         check_abc($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c);
         if (i > 0)
            check($sformatf("vec%0d.period", i), 32'(cyc), 4);
         check($sformatf("vec%0d.overrun", i), 32'(overrun), 0);
         if (vecs[i].load) begin
            tuning_word = vecs[i].tw;
            tw_load     = 1'b1;
         end
      end

      // base wrap with step 2
      do_reset();
      start(32'h02000000);
      for (int k = 1; k <= 128; k++) begin
         wait_valid(20, cyc, ok);
         check($sformatf("wrap%0d.valid", k), 32'(ok), 1);
         base = (2 * k) % 256;
         check_abc($sformatf("wrap%0d", k), base, (base + 85) % 256,
                   (base + 170) % 256);
      end

      // five wait states on the B fetch
      do_reset();
      stall_on   = 1'b1;
      stall_addr = 8'd86;
      start(32'h01000000);
      n = 0;
      while (n < 20 && !busy) begin
         @(negedge clk);
         tw_load = 1'b0;
         n++;
      end
      check("ws.busy_seen", 32'(busy), 1);
      lat = 0;
      while (lat < 30 && !samples_valid) begin
         @(negedge clk);
         lat++;
         if (lat >= 1 && lat <= 6) begin
            check($sformatf("ws.req%0d", lat), 32'(rom_req), 1);
            check($sformatf("ws.addr%0d", lat), 32'(rom_addr), 86);
         end
         if (lat == 6)
            stall_on = 1'b0;
      end
      check("ws.latency", 32'(lat), 8);
      check_abc("ws.first", 1, 86, 171);
      wait_valid(20, cyc, ok);
      check("ws.next_valid", 32'(ok), 1);
      check_abc("ws.dropped", 2, 87, 172);
      check("ws.overrun_set", 32'(overrun), 1);
      flags_clr = 1'b1;
      wait_valid(20, cyc, ok);
      check("ws.clr_valid", 32'(ok), 1);
      check_abc("ws.after_clr", 3, 88, 173);
      check("ws.overrun_clr", 32'(overrun), 0);

      // async reset in the middle of FETCH_B
      do_reset();
      start(32'h01000000);
      wait_valid(20, cyc, ok);
      wait_valid(20, cyc, ok);
      check_abc("ar.pre", 2, 87, 172);
      stall_on   = 1'b1;
      stall_addr = 8'd88;
      n = 0;
      while (n < 20 && !(rom_req && rom_addr == 8'd88)) begin
         @(negedge clk);
         n++;
      end
      check("ar.in_b", 32'(rom_addr), 88);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("ar.req_low", 32'(rom_req), 0);
      check("ar.busy_low", 32'(busy), 0);
      check("ar.valid_low", 32'(samples_valid), 0);
      check_abc("ar.cleared", 0, 0, 0);
      @(negedge clk);
      stall_on = 1'b0;
      reset    = 1'b0;
      start(32'h01000000);
      wait_valid(20, cyc, ok);
      check("ar.valid", 32'(ok), 1);
      check_abc("ar.first", 1, 86, 171);

      // enable dropped during FETCH_A
      do_reset();
      start(32'h01000000);
      n = 0;
      while (n < 20 && !busy) begin
         @(negedge clk);
         tw_load = 1'b0;
         n++;
      end
      check("en.busy_seen", 32'(busy), 1);
      enable = 1'b0;
      wait_valid(10, cyc, ok);
      check("en.completes", 32'(ok), 1);
      check_abc("en.first", 1, 86, 171);
      nv = 0;
      n  = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (samples_valid) nv++;
         if (busy) n++;
      end
      check("en.no_valid", 32'(nv), 0);
      check("en.no_busy", 32'(n), 0);
      enable = 1'b1;
      wait_valid(20, cyc, ok);
      check("en.resume", 32'(ok), 1);
      check("en.resume_lat", 32'(cyc), 7);
      check_abc("en.resume", 2, 87, 172);

`ifdef SPWM_ACK_TIMEOUT_EN
      // ack withheld on C: watchdog aborts without commit
      stall_on   = 1'b1;
      stall_addr = 8'd173;
      n = 0;
      while (n < 20 && !(rom_req && rom_addr == 8'd173)) begin
         @(negedge clk);
         n++;
      end
      check("to.in_c", 32'(rom_addr), 173);
      n  = 1;
      nv = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (samples_valid) nv++;
         if (!busy) break;
         n++;
      end
      enable = 1'b0;
      check("to.cycles", 32'(n), 255);
      check("to.idle", 32'(busy), 0);
      check("to.rom_error", 32'(rom_error), 1);
      check("to.no_valid", 32'(nv), 0);
      check_abc("to.held", 2, 87, 172);
      stall_on = 1'b0;
`else
      check("no_to.rom_error", 32'(rom_error), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
